// File: rtl/muldiv_sequencer.sv
// Multi-cycle HI/LO unit: fixed-latency multiply pipe plus
// 32-step restoring divider, with issue stall while busy.
`ifndef MUL_MTHI
`define MUL_MTHI  3'd0
`define MUL_MTLO  3'd1
`define MUL_MFHI  3'd2
`define MUL_MFLO  3'd3
`define MUL_MULT  3'd4
`define MUL_MULTU 3'd5
`define MUL_DIV   3'd6
`define MUL_DIVU  3'd7
`endif

module muldiv_sequencer #(
  parameter int MUL_LATENCY = 4,
  parameter int DIV_ITERS   = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mul__active,
  input  logic [2:0]  mul__opcode,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] mul__rd_data,
  output logic        mul__stall,
  output logic        mul__busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DFIX = 2'd3;

  logic [1:0]  state;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [5:0]  cnt;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [31:0] rem;
  logic        msign;
  logic        qsign;
  logic        rsign;

  logic        idle;
  logic        accept;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod;
  logic [32:0] shifted;
  logic [33:0] trial;
  logic        fits;
  logic [31:0] abs_rs;
  logic [31:0] abs_rt;
  logic        div_signed;

  assign idle       = (state == S_IDLE);
  assign mul__busy  = ~idle;
  assign mul__stall = mul__active & ~idle;
  assign accept     = mul__active & idle;

  // Sign-extend (or zero-extend) latched operands; low 64 bits
  // of the product are the signed/unsigned result.
  assign ext_a = {{32{msign & opa[31]}}, opa};
  assign ext_b = {{32{msign & opb[31]}}, opb};
  assign prod  = ext_a * ext_b;

  // One restoring step: opa holds the quotient/dividend shift
  // register, opb the divisor, rem the partial remainder.
  assign shifted = {rem, opa[31]};
  assign trial   = {1'b0, shifted} - {2'b0, opb};
  assign fits    = ~trial[33];

  assign div_signed = (mul__opcode == `MUL_DIV);
  assign abs_rs = (div_signed & rs_data[31]) ? -rs_data : rs_data;
  assign abs_rt = (div_signed & rt_data[31]) ? -rt_data : rt_data;

  // MFHI/MFLO read port, zero unless a read is accepted now.
  always_comb begin
    mul__rd_data = 32'd0;
    if (accept && mul__opcode == `MUL_MFHI)
      mul__rd_data = hi;
    else if (accept && mul__opcode == `MUL_MFLO)
      mul__rd_data = lo;
  end

  // Sequencing FSM, HI/LO and operand/partial registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      hi    <= 32'd0;
      lo    <= 32'd0;
      cnt   <= 6'd0;
      opa   <= 32'd0;
      opb   <= 32'd0;
      rem   <= 32'd0;
      msign <= 1'b0;
      qsign <= 1'b0;
      rsign <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            case (mul__opcode)
              `MUL_MTHI: hi <= rs_data;
              `MUL_MTLO: lo <= rs_data;
              `MUL_MULT, `MUL_MULTU: begin
                opa   <= rs_data;
                opb   <= rt_data;
                msign <= (mul__opcode == `MUL_MULT);
                cnt   <= 6'd1;
                state <= S_MUL;
              end
              `MUL_DIV, `MUL_DIVU: begin
                opa   <= abs_rs;
                opb   <= abs_rt;
                rem   <= 32'd0;
                // Zero divisor: quotient stays all-ones and
                // remainder restores to the original rs.
                qsign <= div_signed & (rs_data[31] ^ rt_data[31])
                         & (rt_data != 32'd0);
                rsign <= div_signed & rs_data[31];
                cnt   <= 6'd0;
                state <= S_DIV;
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (cnt == 6'(MUL_LATENCY)) begin
            hi    <= prod[63:32];
            lo    <= prod[31:0];
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        S_DIV: begin
          rem <= fits ? trial[31:0] : shifted[31:0];
          opa <= {opa[30:0], fits};
          cnt <= cnt + 6'd1;
          if (cnt == 6'(DIV_ITERS - 1))
            state <= S_DFIX;
        end
        S_DFIX: begin
          lo    <= qsign ? -opa : opa;
          hi    <= rsign ? -rem : rem;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
